// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the register file with pending-write scoreboard.
package regfile_scoreboard_pkg;

    localparam int unsigned DefWidth   = 16;
    localparam int unsigned DefNumRegs = 8;
    localparam bit          DefBypass  = 1'b1;

    // Select width for a given register count; counts are at least 2 so this is >= 1.
    function automatic int unsigned sel_width(input int unsigned num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/dff_en_n.sv
// Parametrised register with load enable and synchronous active-low reset.
module dff_en_n #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,   // 0 = reset, sampled at posedge
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Reset dominates; otherwise load when enabled.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: two combinational read ports, one write port,
// optional write-to-read bypass and a per-register pending-write (busy) scoreboard.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned SEL_W    = sel_width(NUM_REGS),
    parameter bit          BYPASS   = DefBypass
) (
    input  logic             i_clk,
    input  logic             i_rst,        // synchronous, active-low
    input  logic             i_wr_en,
    input  logic [SEL_W-1:0] i_write_sel,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic [SEL_W-1:0] i_read1_sel,
    input  logic [SEL_W-1:0] i_read2_sel,
    output logic [WIDTH-1:0] o_read1_out,
    output logic [WIDTH-1:0] o_read2_out,
    input  logic             i_rsv_en,
    input  logic [SEL_W-1:0] i_rsv_sel,
    output logic             o_read1_busy,
    output logic             o_read2_busy,
    output logic             o_err
);

    // Register count widened by one bit so the compare never truncates.
    localparam logic [SEL_W:0] NumRegsW = NUM_REGS[SEL_W:0];

    function automatic logic in_range(input logic [SEL_W-1:0] sel);
        return {1'b0, sel} < NumRegsW;
    endfunction

    logic [WIDTH-1:0]    w_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_rsv_hit;
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_busy_d;

    // Per-register enables by compare; out-of-range selects match no index and are dropped.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign w_wr_hit[g]  = i_wr_en  && (i_write_sel == SEL_W'(g));
        assign w_rsv_hit[g] = i_rsv_en && (i_rsv_sel   == SEL_W'(g));

        dff_en_n #(
            .WIDTH (WIDTH)
        ) u_reg (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (w_wr_hit[g]),
            .i_d   (i_data_in),
            .o_q   (w_regs[g])
        );
    end

    // Writeback clears, issue sets; set is applied last so a newer producer wins.
    always_comb begin
        w_busy_d = (w_busy & ~w_wr_hit) | w_rsv_hit;
    end

    dff_en_n #(
        .WIDTH (NUM_REGS)
    ) u_busy (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (1'b1),
        .i_d   (w_busy_d),
        .o_q   (w_busy)
    );

    // Read port 1: guarded array read, bypassed write data masks the busy flag.
    always_comb begin
        o_read1_out  = '0;
        o_read1_busy = 1'b0;
        if (in_range(i_read1_sel)) begin
            if (BYPASS && i_wr_en && (i_write_sel == i_read1_sel)) begin
                o_read1_out = i_data_in;
            end else begin
                o_read1_out  = w_regs[i_read1_sel];
                o_read1_busy = w_busy[i_read1_sel];
            end
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin
        o_read2_out  = '0;
        o_read2_busy = 1'b0;
        if (in_range(i_read2_sel)) begin
            if (BYPASS && i_wr_en && (i_write_sel == i_read2_sel)) begin
                o_read2_out = i_data_in;
            end else begin
                o_read2_out  = w_regs[i_read2_sel];
                o_read2_busy = w_busy[i_read2_sel];
            end
        end
    end

    // Any active select outside the register range this cycle.
    always_comb begin
        o_err = !in_range(i_read1_sel)
             || !in_range(i_read2_sel)
             || (i_wr_en  && !in_range(i_write_sel))
             || (i_rsv_en && !in_range(i_rsv_sel));
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances share stimulus,
// A = 6 registers with bypass, B = 8 registers without bypass.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  write_sel;
    logic [15:0] data_in;
    logic [2:0]  read1_sel;
    logic [2:0]  read2_sel;
    logic        rsv_en;
    logic [2:0]  rsv_sel;

    logic [15:0] a_r1, a_r2, b_r1, b_r2;
    logic        a_b1, a_b2, b_b1, b_b2, a_err, b_err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .WIDTH    (16),
        .NUM_REGS (6),
        .SEL_W    (3),
        .BYPASS   (1'b1)
    ) u_dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_en      (wr_en),
        .i_write_sel  (write_sel),
        .i_data_in    (data_in),
        .i_read1_sel  (read1_sel),
        .i_read2_sel  (read2_sel),
        .o_read1_out  (a_r1),
        .o_read2_out  (a_r2),
        .i_rsv_en     (rsv_en),
        .i_rsv_sel    (rsv_sel),
        .o_read1_busy (a_b1),
        .o_read2_busy (a_b2),
        .o_err        (a_err)
    );

    regfile_scoreboard #(
        .WIDTH    (16),
        .NUM_REGS (8),
        .SEL_W    (3),
        .BYPASS   (1'b0)
    ) u_dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_en      (wr_en),
        .i_write_sel  (write_sel),
        .i_data_in    (data_in),
        .i_read1_sel  (read1_sel),
        .i_read2_sel  (read2_sel),
        .o_read1_out  (b_r1),
        .o_read2_out  (b_r2),
        .i_rsv_en     (rsv_en),
        .i_rsv_sel    (rsv_sel),
        .o_read1_busy (b_b1),
        .o_read2_busy (b_b2),
        .o_err        (b_err)
    );

    // Behavioural model: index 0 mirrors instance A, index 1 instance B.
    int unsigned n_of   [2] = '{6, 8};
    bit          byp_of [2] = '{1'b1, 1'b0};
    logic [15:0] m_regs [2][8];
    logic        m_busy [2][8];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_out(input int d, input logic [2:0] sel);
        if (int'(sel) >= int'(n_of[d])) return 16'h0;
        if (byp_of[d] && wr_en && (write_sel == sel)) return data_in;
        return m_regs[d][sel];
    endfunction

    function automatic logic exp_busy(input int d, input logic [2:0] sel);
        if (int'(sel) >= int'(n_of[d])) return 1'b0;
        if (byp_of[d] && wr_en && (write_sel == sel)) return 1'b0;
        return m_busy[d][sel];
    endfunction

    function automatic logic exp_err(input int d);
        int n;
        n = int'(n_of[d]);
        return (int'(read1_sel) >= n) || (int'(read2_sel) >= n)
            || (wr_en && int'(write_sel) >= n) || (rsv_en && int'(rsv_sel) >= n);
    endfunction

    // Model state update: reset clears everything; write clears busy, reserve then sets it.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                for (int r = 0; r < 8; r++) begin
                    m_regs[d][r] <= 16'h0;
                    m_busy[d][r] <= 1'b0;
                end
            end else begin
                if (wr_en && int'(write_sel) < int'(n_of[d])) begin
                    m_regs[d][write_sel] <= data_in;
                    m_busy[d][write_sel] <= 1'b0;
                end
                if (rsv_en && int'(rsv_sel) < int'(n_of[d])) begin
                    m_busy[d][rsv_sel] <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_a_r1", a_r1, exp_out(0, read1_sel));
            check("cyc_a_r2", a_r2, exp_out(0, read2_sel));
            check("cyc_a_b1", 16'(a_b1), 16'(exp_busy(0, read1_sel)));
            check("cyc_a_b2", 16'(a_b2), 16'(exp_busy(0, read2_sel)));
            check("cyc_a_err", 16'(a_err), 16'(exp_err(0)));
            check("cyc_b_r1", b_r1, exp_out(1, read1_sel));
            check("cyc_b_r2", b_r2, exp_out(1, read2_sel));
            check("cyc_b_b1", 16'(b_b1), 16'(exp_busy(1, read1_sel)));
            check("cyc_b_b2", 16'(b_b2), 16'(exp_busy(1, read2_sel)));
            check("cyc_b_err", 16'(b_err), 16'(exp_err(1)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; write_sel = '0; data_in = '0;
        read1_sel = '0; read2_sel = '0; rsv_en = 1'b0; rsv_sel = '0;
        cyc();
        cyc();
        rst = 1'b1;
        chk_en = 1'b1;

        // Reset state on every in-range select of A
        for (int s = 0; s < 6; s++) begin
            read1_sel = 3'(s);
            read2_sel = 3'(5 - s);
            #1;
            check("rst_a_r1", a_r1, 16'h0);
            check("rst_a_b1", 16'(a_b1), 16'h0);
            check("rst_a_err", 16'(a_err), 16'h0);
            check("rst_b_r2", b_r2, 16'h0);
        end

        // Write BEEF to r3 with same-cycle read on port 2
        cyc();
        wr_en = 1'b1; write_sel = 3'd3; data_in = 16'hBEEF; read1_sel = 3'd0; read2_sel = 3'd3;
        #1;
        check("byp_a_r2", a_r2, 16'hBEEF);
        check("nobyp_b_r2", b_r2, 16'h0);
        cyc();
        wr_en = 1'b0; read1_sel = 3'd3;
        #1;
        check("wr_a_r1", a_r1, 16'hBEEF);
        check("wr_b_r1", b_r1, 16'hBEEF);

        // Reserve r5, then write it back
        cyc();
        rsv_en = 1'b1; rsv_sel = 3'd5; read1_sel = 3'd5;
        #1;
        check("rsv_pre_a_b1", 16'(a_b1), 16'h0);
        cyc();
        rsv_en = 1'b0;
        #1;
        check("rsv_a_b1", 16'(a_b1), 16'h1);
        check("rsv_b_b1", 16'(b_b1), 16'h1);
        cyc();
        wr_en = 1'b1; write_sel = 3'd5; data_in = 16'h0042;
        #1;
        check("wb_a_b1", 16'(a_b1), 16'h0);
        check("wb_a_r1", a_r1, 16'h0042);
        check("wb_b_b1", 16'(b_b1), 16'h1);
        check("wb_b_r1", b_r1, 16'h0);
        cyc();
        wr_en = 1'b0;
        #1;
        check("clr_a_b1", 16'(a_b1), 16'h0);
        check("clr_b_b1", 16'(b_b1), 16'h0);
        check("clr_b_r1", b_r1, 16'h0042);

        // Reserve and write the same register: set wins
        cyc();
        wr_en = 1'b1; write_sel = 3'd2; data_in = 16'h5A5A;
        rsv_en = 1'b1; rsv_sel = 3'd2; read1_sel = 3'd2;
        cyc();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        check("both_a_r1", a_r1, 16'h5A5A);
        check("both_a_b1", 16'(a_b1), 16'h1);
        check("both_b_b1", 16'(b_b1), 16'h1);

        // Out-of-range selects on the 6-register instance
        cyc();
        read1_sel = 3'd7;
        #1;
        check("oor_a_err", 16'(a_err), 16'h1);
        check("oor_a_r1", a_r1, 16'h0);
        check("oor_a_b1", 16'(a_b1), 16'h0);
        check("oor_b_err", 16'(b_err), 16'h0);
        read1_sel = 3'd0;
        wr_en = 1'b1; write_sel = 3'd6; data_in = 16'hFFFF;
        #1;
        check("oorw_a_err", 16'(a_err), 16'h1);
        check("oorw_b_err", 16'(b_err), 16'h0);
        cyc();
        wr_en = 1'b0; rsv_en = 1'b1; rsv_sel = 3'd7; read2_sel = 3'd6;
        #1;
        check("oorr_a_err", 16'(a_err), 16'h1);
        check("oorw_b_r2", b_r2, 16'hFFFF);
        cyc();
        rsv_en = 1'b0; read1_sel = 3'd7;
        #1;
        check("oorr_b_b1", 16'(b_b1), 16'h1);
        check("oorr_a_r2", a_r2, 16'h0);

        // Reset mid-operation discards data, reservations and a concurrent write
        cyc();
        wr_en = 1'b1; write_sel = 3'd1; data_in = 16'h1234; rsv_en = 1'b1; rsv_sel = 3'd4;
        cyc();
        wr_en = 1'b0; rsv_en = 1'b0; read1_sel = 3'd1; read2_sel = 3'd4;
        #1;
        check("pre_a_r1", a_r1, 16'h1234);
        check("pre_a_b2", 16'(a_b2), 16'h1);
        rst = 1'b0; wr_en = 1'b1; write_sel = 3'd3; data_in = 16'hDEAD;
        cyc();
        rst = 1'b1; wr_en = 1'b0;
        #1;
        check("post_a_r1", a_r1, 16'h0);
        check("post_a_b2", 16'(a_b2), 16'h0);
        read2_sel = 3'd3;
        #1;
        check("post_a_r2", a_r2, 16'h0);
        check("post_b_r2", b_r2, 16'h0);

        // Mixed table of writes, reservations and reads, checked every cycle by the model
        for (int i = 0; i < 24; i++) begin
            cyc();
            wr_en     = i[0];
            write_sel = 3'((i * 3) % 8);
            data_in   = 16'(i * 16'h1111 + 1);
            rsv_en    = i[1];
            rsv_sel   = 3'((i * 5) % 8);
            read1_sel = 3'(i % 8);
            read2_sel = 3'((i + 3) % 8);
        end
        cyc();
        wr_en = 1'b0; rsv_en = 1'b0;
        cyc();
        chk_en = 1'b0;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
